// File: rtl/control_sequencer.sv
// control_sequencer
// Microcode control unit for the 8-bit computer. A T-state step counter,
// a carry/zero flags register and a halt latch are held here; every control
// strobe is a combinational decode of (step, opcode, flags).
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   opcode     upper nibble of the instruction register
//   carry_in   ALU carry result (latched when fi=1)
//   zero_in    ALU zero result  (latched when fi=1)
//   hlt        halt request, clock gating happens outside this block
//   mi ri ro io ii ai ao eo su bi oi ce co j fi   control strobes
//   flag_c     latched carry flag
//   flag_z     latched zero flag
//   step       current T-state, 0..4
module control_sequencer #(
  parameter bit EARLY_STEP_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       carry_in,
  input  logic       zero_in,
  output logic       hlt,
  output logic       mi,
  output logic       ri,
  output logic       ro,
  output logic       io,
  output logic       ii,
  output logic       ai,
  output logic       ao,
  output logic       eo,
  output logic       su,
  output logic       bi,
  output logic       oi,
  output logic       ce,
  output logic       co,
  output logic       j,
  output logic       fi,
  output logic       flag_c,
  output logic       flag_z,
  output logic [2:0] step
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  logic [2:0] step_q;
  logic       halted;
  logic       fc_q;
  logic       fz_q;

  // Raw decode, before reset / halt masking.
  logic d_hlt, d_mi, d_ri, d_ro, d_io, d_ii, d_ai, d_ao;
  logic d_eo, d_su, d_bi, d_oi, d_ce, d_co, d_j, d_fi;
  logic [2:0] last_step;
  logic [2:0] step_nxt;
  logic       halt_set;

  always_comb begin
    d_hlt = 1'b0; d_mi = 1'b0; d_ri = 1'b0; d_ro = 1'b0;
    d_io  = 1'b0; d_ii = 1'b0; d_ai = 1'b0; d_ao = 1'b0;
    d_eo  = 1'b0; d_su = 1'b0; d_bi = 1'b0; d_oi = 1'b0;
    d_ce  = 1'b0; d_co = 1'b0; d_j  = 1'b0; d_fi = 1'b0;

    case (step_q)
      T0: begin
        d_co = 1'b1;
        d_mi = 1'b1;
      end
      T1: begin
        d_ro = 1'b1;
        d_ii = 1'b1;
        d_ce = 1'b1;
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            d_io = 1'b1;
            d_mi = 1'b1;
          end
          OP_LDI: begin
            d_io = 1'b1;
            d_ai = 1'b1;
          end
          OP_JMP: begin
            d_io = 1'b1;
            d_j  = 1'b1;
          end
          // Conditional jumps always put the operand on the bus; only the
          // PC load depends on the flag latched by an earlier ADD/SUB.
          OP_JC: begin
            d_io = 1'b1;
            d_j  = fc_q;
          end
          OP_JZ: begin
            d_io = 1'b1;
            d_j  = fz_q;
          end
          OP_OUT: begin
            d_ao = 1'b1;
            d_oi = 1'b1;
          end
          OP_HLT: d_hlt = 1'b1;
          default: ;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            d_ro = 1'b1;
            d_ai = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            d_ro = 1'b1;
            d_bi = 1'b1;
          end
          OP_STA: begin
            d_ao = 1'b1;
            d_ri = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          d_eo = 1'b1;
          d_ai = 1'b1;
          d_fi = 1'b1;
          d_su = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  // Last active microstep per opcode; undefined opcodes behave like NOP.
  always_comb begin
    case (opcode)
      OP_LDA, OP_STA: last_step = T3;
      OP_ADD, OP_SUB: last_step = T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = T2;
      default: last_step = T1;
    endcase
  end

  assign halt_set = (step_q == T2) && (opcode == OP_HLT);

  // HLT freezes the counter at T2 on the very edge the latch sets, so the
  // halted state is always observed as step=2.
  always_comb begin
    if (halted || halt_set) begin
      step_nxt = step_q;
    end else if (step_q >= T4) begin
      step_nxt = T0;
    end else if (EARLY_STEP_RESET && (step_q == last_step)) begin
      step_nxt = T0;
    end else begin
      step_nxt = step_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q <= T0;
      halted <= 1'b0;
      fc_q   <= 1'b0;
      fz_q   <= 1'b0;
    end else begin
      step_q <= step_nxt;
      if (halt_set) begin
        halted <= 1'b1;
      end
      if (d_fi && !halted) begin
        fc_q <= carry_in;
        fz_q <= zero_in;
      end
    end
  end

  // Outputs are masked combinationally by rst so they drop the instant reset
  // asserts, without waiting for the registers or a clock edge.
  logic run;
  assign run = rst && !halted;

  assign hlt = rst && (halted || d_hlt);
  assign mi  = run && d_mi;
  assign ri  = run && d_ri;
  assign ro  = run && d_ro;
  assign io  = run && d_io;
  assign ii  = run && d_ii;
  assign ai  = run && d_ai;
  assign ao  = run && d_ao;
  assign eo  = run && d_eo;
  assign su  = run && d_su;
  assign bi  = run && d_bi;
  assign oi  = run && d_oi;
  assign ce  = run && d_ce;
  assign co  = run && d_co;
  assign j   = run && d_j;
  assign fi  = run && d_fi;

  assign flag_c = fc_q;
  assign flag_z = fz_q;
  assign step   = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  logic       clk;
  logic       rst_a, rst_b;
  logic [3:0] opcode_a, opcode_b;
  logic       carry_in, zero_in;

  logic       hlt_a, mi_a, ri_a, ro_a, io_a, ii_a, ai_a, ao_a;
  logic       eo_a, su_a, bi_a, oi_a, ce_a, co_a, j_a, fi_a;
  logic       fc_a, fz_a;
  logic [2:0] step_a;

  logic       hlt_b, mi_b, ri_b, ro_b, io_b, ii_b, ai_b, ao_b;
  logic       eo_b, su_b, bi_b, oi_b, ce_b, co_b, j_b, fi_b;
  logic       fc_b, fz_b;
  logic [2:0] step_b;

  logic [15:0] ctrl_a, ctrl_b;
  assign ctrl_a = {hlt_a, mi_a, ri_a, ro_a, io_a, ii_a, ai_a, ao_a,
                   eo_a, su_a, bi_a, oi_a, ce_a, co_a, j_a, fi_a};
  assign ctrl_b = {hlt_b, mi_b, ri_b, ro_b, io_b, ii_b, ai_b, ao_b,
                   eo_b, su_b, bi_b, oi_b, ce_b, co_b, j_b, fi_b};

  int passed = 0;
  int total  = 0;

  control_sequencer #(.EARLY_STEP_RESET(1'b1)) dut_a (
    .clk(clk), .rst(rst_a), .opcode(opcode_a),
    .carry_in(carry_in), .zero_in(zero_in),
    .hlt(hlt_a), .mi(mi_a), .ri(ri_a), .ro(ro_a), .io(io_a), .ii(ii_a),
    .ai(ai_a), .ao(ao_a), .eo(eo_a), .su(su_a), .bi(bi_a), .oi(oi_a),
    .ce(ce_a), .co(co_a), .j(j_a), .fi(fi_a),
    .flag_c(fc_a), .flag_z(fz_a), .step(step_a)
  );

  control_sequencer #(.EARLY_STEP_RESET(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(opcode_b),
    .carry_in(carry_in), .zero_in(zero_in),
    .hlt(hlt_b), .mi(mi_b), .ri(ri_b), .ro(ro_b), .io(io_b), .ii(ii_b),
    .ai(ai_b), .ao(ao_b), .eo(eo_b), .su(su_b), .bi(bi_b), .oi(oi_b),
    .ce(ce_b), .co(co_b), .j(j_b), .fi(fi_b),
    .flag_c(fc_b), .flag_z(fz_b), .step(step_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock and settle at the falling edge, where outputs are
  // sampled; also confirm no two bus drivers are active at once.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("bus_a", 32'($countones({co_a, ro_a, io_a, ao_a, eo_a}) <= 1), 32'd1);
    check("bus_b", 32'($countones({co_b, ro_b, io_b, ao_b, eo_b}) <= 1), 32'd1);
  endtask

  // Run a full ADD/SUB from T0 through T4 and into the next T0.
  task automatic run_alu(input logic [3:0] op, input logic c, input logic z);
    opcode_a = op;
    carry_in = c;
    zero_in  = z;
    tick();  // T1
    tick();  // T2
    tick();  // T3
    tick();  // T4
    check("alu_t4", ctrl_a, C_EO | C_AI | C_FI | ((op == 4'b0011) ? C_SU : 16'h0));
    tick();  // back to T0
    check("alu_step0", step_a, 0);
    check("alu_fc", fc_a, c);
    check("alu_fz", fz_a, z);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    opcode_a = 4'b0000; opcode_b = 4'b0101;
    carry_in = 1'b0; zero_in = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_step", step_a, 0);
    check("rst_ctrl", ctrl_a, 0);
    check("rst_flags", {fc_a, fz_a}, 0);
    check("rst_ctrl_b", ctrl_b, 0);

    // NOP fetch loop, early step reset
    rst_a = 1'b1;
    #1;
    check("nop_t0", ctrl_a, C_CO | C_MI);
    check("nop_t0_step", step_a, 0);
    @(negedge clk);
    check("nop_t1", ctrl_a, C_RO | C_II | C_CE);
    check("nop_t1_step", step_a, 1);
    tick();
    check("nop_wrap", step_a, 0);
    tick();
    check("nop_step1b", step_a, 1);
    tick();
    check("nop_step0b", step_a, 0);

    // SUB with carry=zero=1
    run_alu(4'b0011, 1'b1, 1'b1);
    // ADD clearing both flags
    run_alu(4'b0010, 1'b0, 1'b0);

    // JC with flag_c=0
    opcode_a = 4'b0111;
    carry_in = 1'b1; zero_in = 1'b1;
    tick(); tick();
    check("jc0_t2", ctrl_a, C_IO);
    tick();
    check("jc0_step", step_a, 0);
    check("jc0_flags", {fc_a, fz_a}, 0);

    // ADD leaving carry=1, zero=0; then JC taken, JZ not taken
    run_alu(4'b0010, 1'b1, 1'b0);
    opcode_a = 4'b0111;
    tick(); tick();
    check("jc1_t2", ctrl_a, C_IO | C_J);
    tick();
    check("jc1_step", step_a, 0);
    opcode_a = 4'b1000;
    tick(); tick();
    check("jz0_t2", ctrl_a, C_IO);
    tick();

    // STA and OUT
    opcode_a = 4'b0100;
    tick(); tick();
    check("sta_t2", ctrl_a, C_IO | C_MI);
    tick();
    check("sta_t3", ctrl_a, C_AO | C_RI);
    tick();
    check("sta_step", step_a, 0);
    opcode_a = 4'b1110;
    tick(); tick();
    check("out_t2", ctrl_a, C_AO | C_OI);
    tick();

    // LDA with an asynchronous reset in the middle of T3
    opcode_a = 4'b0001;
    tick(); tick();
    check("lda_t2", ctrl_a, C_IO | C_MI);
    tick();
    check("lda_t3", ctrl_a, C_RO | C_AI);
    check("lda_fc_pre", fc_a, 1);
    #2 rst_a = 1'b0;
    #1;
    check("arst_step", step_a, 0);
    check("arst_flags", {fc_a, fz_a}, 0);
    check("arst_ctrl", ctrl_a, 0);
    @(negedge clk);
    rst_a = 1'b1;

    // HLT
    opcode_a = 4'b1111;
    tick(); tick();
    check("hlt_t2", ctrl_a, C_HLT);
    check("hlt_t2_step", step_a, 2);
    repeat (10) tick();
    check("hlt_hold_step", step_a, 2);
    check("hlt_hold_ctrl", ctrl_a, C_HLT);
    #2 rst_a = 1'b0;
    #1;
    check("hlt_rst_ctrl", ctrl_a, 0);
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    check("hlt_rel_step", step_a, 0);
    check("hlt_rel_hlt", hlt_a, 0);
    check("hlt_rel_ctrl", ctrl_a, C_CO | C_MI);

    // Full T0..T4 run with EARLY_STEP_RESET=0, LDI
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    check("b_t0", ctrl_b, C_CO | C_MI);
    tick();
    check("b_t1", ctrl_b, C_RO | C_II | C_CE);
    tick();
    check("b_t2", ctrl_b, C_IO | C_AI);
    check("b_t2_step", step_b, 2);
    tick();
    check("b_t3", ctrl_b, 0);
    check("b_t3_step", step_b, 3);
    tick();
    check("b_t4", ctrl_b, 0);
    check("b_t4_step", step_b, 4);
    tick();
    check("b_wrap", step_b, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
